// File: rtl/mul_appr_share_ctrl.sv
// mul_appr_share_ctrl
//   Shares one combinational BITxBIT multiplier between NREQ requesters. A
//   round-robin arbiter picks one requester per cycle. The operands go through
//   a two-stage pipeline: S0 holds the operands that drive the multiplier, and
//   S1 holds the captured product that is presented as the response.
//
// Ports
//   clk, rst   rising-edge clock, synchronous active-high reset
//   req_valid  per-requester operand valid
//   req_ready  per-requester accept. It is one-hot or zero.
//   req_a/b    packed operands; requester i sits at [i*BIT +: BIT]
//   mul_a/b    registered operands to the external multiplier
//   mul_p      product, combinational from mul_a/mul_b
//   rsp_valid  response valid
//   rsp_ready  response accept
//   rsp_id     requester ID of the response
//   rsp_data   product
//   op_cnt     number of completed responses; wraps
//
// Handshake: a request moves on a rising edge where req_valid[i] & req_ready[i]
// are both high. A response moves on a rising edge where rsp_valid & rsp_ready
// are both high. Once rsp_valid is raised, it stays high and rsp_id/rsp_data
// stay stable until the response is accepted.
module mul_appr_share_ctrl #(
  parameter int NREQ = 4,
  parameter int BIT  = 16,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*BIT-1:0] req_a,
  input  logic [NREQ*BIT-1:0] req_b,
  output logic [BIT-1:0]      mul_a,
  output logic [BIT-1:0]      mul_b,
  input  logic [2*BIT-1:0]    mul_p,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*BIT-1:0]    rsp_data,
  output logic [31:0]         op_cnt
);

  logic             v0_q, v0_d, v1_q, v1_d;
  logic [BIT-1:0]   a0_q, a0_d, b0_q, b0_d;
  logic [IDW-1:0]   id0_q, id0_d, id1_q, id1_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [2*BIT-1:0] p1_q, p1_d;
  logic [31:0]      op_cnt_q, op_cnt_d;

  logic             adv0, adv1, take, rsp_xfer;
  logic             grant_any;
  int               winner;
  logic [BIT-1:0]   win_a, win_b;

  assign adv1     = !v1_q || rsp_ready;
  assign adv0     = !v0_q || adv1;
  assign rsp_xfer = v1_q && rsp_ready;
  // No grant is issued while reset is asserted.
  assign take     = grant_any && adv0 && !rst;

  // Round-robin search. Each valid requester is ranked by its distance above
  // ptr (mod NREQ), and the nearest one wins. This is the same as the first
  // valid requester found when scanning upward from ptr.
  always_comb begin : arb
    int best_d;
    int d;
    grant_any = 1'b0;
    winner    = 0;
    best_d    = NREQ;
    d         = 0;
    win_a     = '0;
    win_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        d = i - int'(ptr_q);
        if (d < 0) d = d + NREQ;
        if (d < best_d) begin
          best_d    = d;
          winner    = i;
          grant_any = 1'b1;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (winner == i) begin
        win_a = req_a[i*BIT +: BIT];
        win_b = req_b[i*BIT +: BIT];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = take && (winner == i);
    end
  end

  always_comb begin : next_state
    int nxt;
    v0_d     = v0_q;
    a0_d     = a0_q;
    b0_d     = b0_q;
    id0_d    = id0_q;
    v1_d     = v1_q;
    p1_d     = p1_q;
    id1_d    = id1_q;
    ptr_d    = ptr_q;
    op_cnt_d = op_cnt_q + 32'(rsp_xfer);
    nxt      = winner + 1;
    if (nxt >= NREQ) nxt = 0;

    if (take) ptr_d = IDW'(nxt);

    // When S0 loads with no grant, it becomes a bubble. The operands are
    // kept so the multiplier inputs do not toggle.
    if (adv0) begin
      v0_d = take;
      if (take) begin
        a0_d  = win_a;
        b0_d  = win_b;
        id0_d = IDW'(winner);
      end
    end

    if (adv1) begin
      v1_d  = v0_q;
      p1_d  = mul_p;
      id1_d = id0_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q     <= 1'b0;
      a0_q     <= '0;
      b0_q     <= '0;
      id0_q    <= '0;
      v1_q     <= 1'b0;
      p1_q     <= '0;
      id1_q    <= '0;
      ptr_q    <= '0;
      op_cnt_q <= '0;
    end else begin
      v0_q     <= v0_d;
      a0_q     <= a0_d;
      b0_q     <= b0_d;
      id0_q    <= id0_d;
      v1_q     <= v1_d;
      p1_q     <= p1_d;
      id1_q    <= id1_d;
      ptr_q    <= ptr_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  assign mul_a     = a0_q;
  assign mul_b     = b0_q;
  assign rsp_valid = v1_q;
  assign rsp_id    = id1_q;
  assign rsp_data  = p1_q;
  assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_mul_appr_share_ctrl.sv
// Testbench for mul_appr_share_ctrl. An exact multiplier model sits beside
// the DUT. A reference model of the arbiter and pipeline predicts req_ready
// and rsp_valid. Each accepted request queues {id, product}, and each
// accepted response pops the queue and is compared against it.
module tb_mul_appr_share_ctrl;

  localparam int NREQ = 4;
  localparam int BIT  = 16;
  localparam int IDW  = 2;
  localparam int EW   = IDW + 2*BIT;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*BIT-1:0] req_a;
  logic [NREQ*BIT-1:0] req_b;
  logic [BIT-1:0]      mul_a;
  logic [BIT-1:0]      mul_b;
  logic [2*BIT-1:0]    mul_p;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [2*BIT-1:0]    rsp_data;
  logic [31:0]         op_cnt;

  mul_appr_share_ctrl #(.NREQ(NREQ), .BIT(BIT), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .op_cnt    (op_cnt)
  );

  // Exact multiplier stand-in.
  assign mul_p = {{BIT{1'b0}}, mul_a} * {{BIT{1'b0}}, mul_b};

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  logic [EW-1:0] exp_q[$];
  int            gnt_log[$];
  logic          m_v0, m_v1;
  int            m_ptr;
  logic [31:0]   cnt_model;
  int            total, bad;
  int            grant_cnt;
  int            gnt_id;
  logic          auto_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom_range(0, 16'hFFFF));
  endfunction

  task automatic reset_model();
    exp_q.delete();
    m_v0      = 1'b0;
    m_v1      = 1'b0;
    m_ptr     = 0;
    cnt_model = '0;
  endtask

  // Runs one clock cycle. The task is called at a falling edge with the
  // inputs already set. It first checks the outputs before the rising edge.
  // It then books the transfers that happen on that edge and advances the
  // model. Finally it waits for the next falling edge.
  task automatic tick();
    logic [NREQ-1:0]     exp_rdy, drop, tmp;
    logic [NREQ*BIT-1:0] sa, sb;
    logic [2*BIT-1:0]    pa, pb;
    logic [EW-1:0]       got, want;
    logic                a1, a0v;
    int                  w, idx;
    #1;
    a1  = !m_v1 || rsp_ready;
    a0v = !m_v0 || a1;
    w   = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      tmp = req_valid >> idx;
      if (w < 0 && tmp[0]) w = idx;
    end
    exp_rdy = '0;
    if (a0v && w >= 0) exp_rdy = NREQ'(1) << w;

    chk("rsp_valid", rsp_valid, m_v1);
    chk("req_ready", req_ready, exp_rdy);
    chk("op_cnt", op_cnt, cnt_model);

    if (rsp_valid && rsp_ready) begin
      chk("rsp_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {rsp_id, rsp_data};
        chk("rsp_id_data", got, want);
      end
      cnt_model = cnt_model + 32'd1;
    end

    gnt_id = -1;
    for (int i = 0; i < NREQ; i++) begin
      tmp = req_ready >> i;
      if (tmp[0]) gnt_id = i;
    end
    if (gnt_id >= 0) begin
      grant_cnt++;
      gnt_log.push_back(gnt_id);
    end

    drop = '0;
    if (exp_rdy != 0) begin
      sa   = req_a >> (w*BIT);
      sb   = req_b >> (w*BIT);
      pa   = {{BIT{1'b0}}, sa[BIT-1:0]};
      pb   = {{BIT{1'b0}}, sb[BIT-1:0]};
      want = {IDW'(w), pa * pb};
      exp_q.push_back(want);
      m_ptr = (w + 1) % NREQ;
      if (auto_drop) drop = exp_rdy;
    end
    if (a1)  m_v1 = m_v0;
    if (a0v) m_v0 = (exp_rdy != 0);

    @(negedge clk);
    req_valid = req_valid & ~drop;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || m_v0 || m_v1) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int   g0, n, found;
    logic [2*BIT-1:0] held;
    total     = 0;
    bad       = 0;
    grant_cnt = 0;
    gnt_id    = -1;
    auto_drop = 1'b0;
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    reset_model();

    // Reset state. All requesters are valid but none may be granted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_op_cnt", op_cnt, 0);
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);

    // 1. Single operation, 3*5.
    req_a     = {48'h0, 16'd3};
    req_b     = {48'h0, 16'd5};
    req_valid = 4'b0001;
    tick();
    chk("t1_gnt", gnt_id, 0);
    req_valid = '0;
    chk("t1_lat1", rsp_valid, 0);
    tick();
    chk("t1_lat2", rsp_valid, 1);
    chk("t1_id", rsp_id, 0);
    chk("t1_data", rsp_data, 15);
    tick();
    chk("t1_opcnt", op_cnt, 1);
    drain();

    // 2. All requesters valid every cycle. After test 1 the pointer sits at
    //    1, so the grants rotate 1,2,3,0,...
    gnt_log.delete();
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      req_a = {rnd16(), rnd16(), rnd16(), rnd16()};
      req_b = {rnd16(), rnd16(), rnd16(), rnd16()};
      tick();
    end
    chk("t2_ngrants", gnt_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("t2_order", gnt_log[k], (1 + k) % NREQ);
    end
    drain();

    // 3. Backpressure with three requests offered. Only S0 and S1 can fill.
    auto_drop = 1'b1;
    rsp_ready = 1'b0;
    req_a     = {rnd16(), rnd16(), rnd16(), rnd16()};
    req_b     = {rnd16(), rnd16(), rnd16(), rnd16()};
    req_valid = 4'b0111;
    g0        = grant_cnt;
    tick();
    tick();
    held = rsp_data;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_stable", rsp_data, held);
    end
    chk("t3_two_accepted", grant_cnt - g0, 2);
    rsp_ready = 1'b1;
    n = 0;
    while (req_valid != 0 && n < 10) begin
      tick();
      n++;
    end
    chk("t3_third_accepted", grant_cnt - g0, 3);
    drain();
    auto_drop = 1'b0;

    // 4. Fairness. Requester 2 is always valid, and requester 0 joins later.
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_only2", gnt_id, 2);
    end
    req_valid = 4'b0101;
    found = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (found == 0) begin
        tick();
        if (gnt_id == 0) found = 1;
      end
    end
    chk("t4_req0_fair", found, 1);
    drain();

    // 5. Reset while both stages are full.
    req_valid = '1;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("t5_full", rsp_valid, 1);
    rst = 1'b1;
    #1;
    chk("t5_rdy_in_rst", req_ready, 0);
    @(negedge clk);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_op_cnt", op_cnt, 0);
    chk("t5_rdy_rst", req_ready, 0);
    reset_model();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    tick();
    chk("t5_first_gnt", gnt_id, 0);
    drain();

    // 6. Counter wrap. The forced value is held across one idle edge.
    force dut.op_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.op_cnt_q;
    #1;
    cnt_model = 32'hFFFF_FFFF;
    chk("t6_preset", op_cnt, 32'hFFFF_FFFF);
    req_a     = {rnd16(), 48'h0};
    req_b     = {rnd16(), 48'h0};
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    drain();
    chk("t6_wrap", op_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
